// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data_memory port between the core MEM stage and a debug master
// Optional starvation guard for the debug master: DMEM_ARB_STARVE_GUARD_EN.

package defines;
   parameter int DATA_WIDTH = 32;
   localparam logic [2:0] FUNCT3_LW = 3'b010;
   localparam logic [2:0] FUNCT3_SW = 3'b010;
endpackage

module dmem_port_arbiter #(
   parameter int DATA_WIDTH = defines::DATA_WIDTH,
   parameter int MAX_WAIT   = 8,
   parameter int CNT_W      = $clog2(MAX_WAIT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_req_i,
   input  logic                  core_we_i,
   input  logic [2:0]            core_funct3_i,
   input  logic [DATA_WIDTH-1:0] core_addr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   output logic                  core_stall_o,
   output logic                  core_rvalid_o,
   input  logic                  dbg_valid_i,
   output logic                  dbg_ready_o,
   input  logic                  dbg_we_i,
   input  logic [DATA_WIDTH-1:0] dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   output logic                  dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o,
   output logic                  mem_we_o,
   output logic                  mem_re_o,
   output logic [2:0]            mem_funct3_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   logic force_dbg;
   logic grant_core;
   logic grant_dbg;
   logic rd_core_q;
   logic rd_dbg_q;
   logic unused_dbg_addr_lsb;

   // Grants are gated by rst so nothing reaches memory while reset is held.
   assign grant_core   = !rst && core_req_i && !force_dbg;
   assign grant_dbg    = !rst && dbg_valid_i && (!core_req_i || force_dbg);
   assign core_stall_o = core_req_i && !grant_core;
   assign dbg_ready_o  = grant_dbg;

   assign unused_dbg_addr_lsb = ^dbg_addr_i[1:0];

   always_comb begin
      mem_we_o     = 1'b0;
      mem_re_o     = 1'b0;
      mem_funct3_o = 3'b000;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      if (grant_core) begin
         mem_we_o     = core_we_i;
         mem_re_o     = !core_we_i;
         mem_funct3_o = core_funct3_i;
         mem_addr_o   = core_addr_i;
         mem_wdata_o  = core_wdata_i;
      end else if (grant_dbg) begin
         mem_we_o     = dbg_we_i;
         mem_re_o     = !dbg_we_i;
         mem_funct3_o = dbg_we_i ? defines::FUNCT3_SW : defines::FUNCT3_LW;
         mem_addr_o   = {dbg_addr_i[DATA_WIDTH-1:2], 2'b00};
         mem_wdata_o  = dbg_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_core_q <= 1'b0;
         rd_dbg_q  <= 1'b0;
      end else begin
         rd_core_q <= grant_core && !core_we_i;
         rd_dbg_q  <= grant_dbg && !dbg_we_i;
      end
   end

   // A read return already in flight when reset rises is suppressed immediately.
   assign core_rvalid_o = rd_core_q && !rst;
   assign dbg_rvalid_o  = rd_dbg_q && !rst;
   assign dbg_rdata_o   = dbg_rvalid_o ? mem_rdata_i : '0;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             dbg_hs;

   assign force_dbg = (state_q == ARB_FORCE);
   assign dbg_hs    = dbg_valid_i && grant_dbg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_NORMAL;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ARB_NORMAL: begin
            if (dbg_hs) begin
               wait_cnt_d = '0;
            end else if (dbg_valid_i) begin
               if (wait_cnt_q != MAX_CNT) wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_d == MAX_CNT) state_d = ARB_FORCE;
            end
         end
         ARB_FORCE: begin
            if (dbg_hs || !dbg_valid_i) begin
               state_d    = ARB_NORMAL;
               wait_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ARB_NORMAL;
            wait_cnt_d = '0;
         end
      endcase
   end
`else
   assign force_dbg = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter with a 1-cycle memory model

module tb_dmem_port_arbiter;

   localparam logic [2:0] F3_W = 3'b010;

   typedef struct {
      bit          is_dbg;
      logic [31:0] data;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req_i, core_we_i;
   logic [2:0]  core_funct3_i;
   logic [31:0] core_addr_i, core_wdata_i;
   logic        core_stall_o, core_rvalid_o;
   logic        dbg_valid_i, dbg_ready_o, dbg_we_i;
   logic [31:0] dbg_addr_i, dbg_wdata_i;
   logic        dbg_rvalid_o;
   logic [31:0] dbg_rdata_o;
   logic        mem_we_o, mem_re_o;
   logic [2:0]  mem_funct3_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata_i;

   logic [31:0] mem [0:1023];
   rd_exp_t     exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cycles = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_funct3_i(core_funct3_i),
      .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_stall_o(core_stall_o), .core_rvalid_o(core_rvalid_o),
      .dbg_valid_i(dbg_valid_i), .dbg_ready_o(dbg_ready_o), .dbg_we_i(dbg_we_i),
      .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
      .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
      .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_funct3_o(mem_funct3_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // data_memory stand-in: word writes, registered read data
   always @(posedge clk) begin
      if (mem_we_o) mem[mem_addr_o[11:2]] <= mem_wdata_o;
      if (mem_re_o) mem_rdata_i <= mem[mem_addr_o[11:2]];
   end

   always @(posedge clk) begin
      cycles <= cycles + 1;
      if (cycles > 5000) begin
         $display("FAIL watchdog: cycles=%0d limit=5000", cycles);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every read return is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (core_rvalid_o && dbg_rvalid_o) chk("both_rvalid", 32'd1, 32'd0);
      if (core_rvalid_o || dbg_rvalid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", {31'd0, dbg_rvalid_o}, 32'hFFFF_FFFF);
         end else begin
            rd_exp_t e;
            e = exp_q.pop_front();
            chk("rvalid_owner", {31'd0, dbg_rvalid_o}, {31'd0, e.is_dbg});
            chk("rdata", e.is_dbg ? dbg_rdata_o : mem_rdata_i, e.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req_i = 1'b0; core_we_i = 1'b0; core_funct3_i = 3'b0;
      core_addr_i = '0; core_wdata_i = '0;
      dbg_valid_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
   endtask

   task automatic dbg_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      dbg_valid_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
   endtask

   task automatic core_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      core_req_i = 1'b1; core_we_i = we; core_funct3_i = F3_W; core_addr_i = addr; core_wdata_i = wd;
   endtask

   task automatic push(input bit is_dbg, input logic [31:0] d);
      rd_exp_t e;
      e.is_dbg = is_dbg;
      e.data   = d;
      exp_q.push_back(e);
   endtask

   initial begin
      mem[10'h300 >> 2] = 32'h4433_2211;
      mem[10'h304 >> 2] = 32'h5566_7788;
      mem[11'h400 >> 2] = 32'h1234_5678;
      mem[11'h504 >> 2] = 32'hCAFE_F00D;
      mem_rdata_i = '0;
      idle();
      rst = 1'b1;
      core_req_i = 1'b1;
      dbg_valid_i = 1'b1;
      step(); step();
      #1;
      chk("rst_stall", {31'd0, core_stall_o}, 32'd1);
      chk("rst_ready", {31'd0, dbg_ready_o}, 32'd0);
      chk("rst_mem_en", {30'd0, mem_we_o, mem_re_o}, 32'd0);
      step();
      rst = 1'b0;
      idle();
      step();

      // 1: debug only, write then read back
      dbg_req(1'b1, 32'h100, 32'hDEAD_BEEF);
      #1;
      chk("t1_wr_ready", {31'd0, dbg_ready_o}, 32'd1);
      chk("t1_wr_f3", {29'd0, mem_funct3_o}, {29'd0, F3_W});
      chk("t1_wr_we", {31'd0, mem_we_o}, 32'd1);
      step();
      dbg_req(1'b0, 32'h100, 32'h0);
      #1;
      chk("t1_rd_ready", {31'd0, dbg_ready_o}, 32'd1);
      chk("t1_rd_re", {30'd0, mem_we_o, mem_re_o}, 32'd1);
      push(1'b1, 32'hDEAD_BEEF);
      step();
      idle();
      #1;
      chk("t1_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      step();

      // 2: same-cycle collision, core wins
      core_cmd(1'b1, 32'h200, 32'hAAAA_AAAA);
      dbg_req(1'b0, 32'h200, 32'h0);
      #1;
      chk("t2_stall", {31'd0, core_stall_o}, 32'd0);
      chk("t2_ready", {31'd0, dbg_ready_o}, 32'd0);
      chk("t2_mem_addr", mem_addr_o, 32'h200);
      step();
      core_req_i = 1'b0;
      #1;
      chk("t2_ready2", {31'd0, dbg_ready_o}, 32'd1);
      push(1'b1, 32'hAAAA_AAAA);
      step();
      idle();
      step();

      // 4: alternating reads on consecutive cycles
      core_cmd(1'b0, 32'h300, 32'h0);
      push(1'b0, 32'h4433_2211);
      step();
      core_req_i = 1'b0;
      dbg_req(1'b0, 32'h304, 32'h0);
      #1;
      chk("t4_dbg_ready", {31'd0, dbg_ready_o}, 32'd1);
      chk("t4_core_rvalid", {31'd0, core_rvalid_o}, 32'd1);
      push(1'b1, 32'h5566_7788);
      step();
      idle();
      step();

      // 5: misaligned debug address
      dbg_req(1'b0, 32'h403, 32'h0);
      #1;
      chk("t5_addr", mem_addr_o, 32'h400);
      chk("t5_f3", {29'd0, mem_funct3_o}, {29'd0, F3_W});
      push(1'b1, 32'h1234_5678);
      step();
      idle();
      step();

      // 3: starvation under continuous core stores
      core_cmd(1'b1, 32'h500, 32'h0BAD_0BAD);
      dbg_req(1'b0, 32'h504, 32'h0);
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int c = 1; c <= 9; c++) begin
         #1;
         chk($sformatf("t3_ready_c%0d", c), {31'd0, dbg_ready_o}, (c == 9) ? 32'd1 : 32'd0);
         chk($sformatf("t3_stall_c%0d", c), {31'd0, core_stall_o}, (c == 9) ? 32'd1 : 32'd0);
         if (c == 9) push(1'b1, 32'hCAFE_F00D);
         step();
      end
      dbg_valid_i = 1'b0;
      #1;
      chk("t3_stall_after", {31'd0, core_stall_o}, 32'd0);
`else
      for (int c = 1; c <= 20; c++) begin
         #1;
         chk($sformatf("t3_ready_c%0d", c), {31'd0, dbg_ready_o}, 32'd0);
         chk($sformatf("t3_stall_c%0d", c), {31'd0, core_stall_o}, 32'd0);
         step();
      end
      core_req_i = 1'b0;
      #1;
      chk("t3_ready_free", {31'd0, dbg_ready_o}, 32'd1);
      push(1'b1, 32'hCAFE_F00D);
`endif
      step();
      idle();
      step();

      // 6: reset in the cycle after a debug read grant
      dbg_req(1'b0, 32'h100, 32'h0);
      #1;
      chk("t6_ready", {31'd0, dbg_ready_o}, 32'd1);
      step();
      idle();
      rst = 1'b1;
      #1;
      chk("t6_rvalid_dropped", {31'd0, dbg_rvalid_o}, 32'd0);
      step();
      rst = 1'b0;
      dbg_req(1'b0, 32'h100, 32'h0);
      #1;
      chk("t6_ready_after", {31'd0, dbg_ready_o}, 32'd1);
      push(1'b1, 32'hDEAD_BEEF);
      step();
      idle();
      step(); step();

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
